// File: rtl/sha256_digest_checker.sv
// rtl/sha256_digest_checker.sv - reads an 8-word SHA-256 digest from memory and checks it
//
// Purpose: after the hash core finishes, fetch the digest words at hash_addr,
// pack them into a 256-bit register, compare against expected_digest and hand
// the result to the host over a valid/ready handshake.
//
// Optional feature macro: SHA256_DIFFICULTY_CHECK_EN (leading-zero count and
// difficulty target check). When undefined, leading_zeros and meets_target
// stay 0 and difficulty is ignored; the port list does not change.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a check (sampled only in IDLE)
//   hash_addr         base word address of the digest
//   expected_digest   reference digest, [255:224] = h0
//   difficulty        required leading-zero bit count
//   memory_clk        copy of clk for the shared memory
//   enable_write      tied 0, this block only reads
//   memory_addr       registered read address
//   memory_read_data  synchronous-read data for last cycle's address
//   digest            captured digest, word0 in [255:224]
//   match             digest == expected_digest
//   leading_zeros     leading zero bits of digest (0..256)
//   meets_target      leading_zeros >= difficulty
//   digest_valid      result available
//   digest_ready      consumer accepts result
//   done              high while idle
module sha256_digest_checker #(
  parameter int NUM_HASH_WORDS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [15:0]  hash_addr,
  input  logic [255:0] expected_digest,
  input  logic [7:0]   difficulty,
  output logic         memory_clk,
  output logic         enable_write,
  output logic [15:0]  memory_addr,
  input  logic [31:0]  memory_read_data,
  output logic [255:0] digest,
  output logic         match,
  output logic [8:0]   leading_zeros,
  output logic         meets_target,
  output logic         digest_valid,
  input  logic         digest_ready,
  output logic         done
);

  localparam int CNT_W = $clog2(NUM_HASH_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_HASH_WORDS);

  typedef enum logic [1:0] {IDLE, READ, COMPARE, HOLD} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  // Words are shifted in here during READ so the visible digest only changes
  // in COMPARE; the previous result stays intact while a new read runs.
  logic [255:0]     assembled;
  logic [8:0]       lz_next;
  logic             meets_next;

  assign memory_clk = clk;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = READ;
      READ:    if (cnt == LAST_CNT) state_next = COMPARE;
      COMPARE: state_next = HOLD;
      HOLD:    if (digest_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    done         = (state == IDLE);
    enable_write = 1'b0;
  end

`ifdef SHA256_DIFFICULTY_CHECK_EN
  // Scanning from the LSB upward, the last set bit seen is the most
  // significant one, so it decides the count.
  always_comb begin
    lz_next = 9'd256;
    for (int i = 0; i < 256; i++) begin
      if (assembled[i]) lz_next = 9'(255 - i);
    end
    meets_next = (lz_next >= {1'b0, difficulty});
  end
`else
  logic unused_difficulty;
  assign unused_difficulty = ^difficulty;
  always_comb begin
    lz_next    = 9'd0;
    meets_next = 1'b0;
  end
`endif

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memory_addr   <= 16'd0;
      cnt           <= '0;
      assembled     <= '0;
      digest        <= '0;
      match         <= 1'b0;
      leading_zeros <= 9'd0;
      meets_target  <= 1'b0;
      digest_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            memory_addr <= hash_addr;
            cnt         <= '0;
          end
        end
        READ: begin
          // cnt = 0 is the memory latency cycle: nothing valid to capture yet.
          if (cnt != '0) assembled <= {assembled[223:0], memory_read_data};
          // Address stops at hash_addr + NUM_HASH_WORDS on the last capture.
          if (cnt != LAST_CNT) begin
            memory_addr <= memory_addr + 16'd1;
            cnt         <= cnt + CNT_W'(1);
          end
        end
        COMPARE: begin
          digest        <= assembled;
          match         <= (assembled == expected_digest);
          leading_zeros <= lz_next;
          meets_target  <= meets_next;
          digest_valid  <= 1'b1;
        end
        HOLD: begin
          if (digest_ready) digest_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_digest_checker.sv
// tb/tb_sha256_digest_checker.sv - scoreboard bench for sha256_digest_checker
module tb_sha256_digest_checker;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [15:0]  hash_addr = 16'd0;
  logic [255:0] expected_digest = '0;
  logic [7:0]   difficulty = 8'd0;
  logic         memory_clk;
  logic         enable_write;
  logic [15:0]  memory_addr;
  logic [31:0]  memory_read_data = 32'd0;
  logic [255:0] digest;
  logic         match;
  logic [8:0]   leading_zeros;
  logic         meets_target;
  logic         digest_valid;
  logic         digest_ready = 1'b0;
  logic         done;

  sha256_digest_checker #(.NUM_HASH_WORDS(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hash_addr(hash_addr),
    .expected_digest(expected_digest), .difficulty(difficulty),
    .memory_clk(memory_clk), .enable_write(enable_write),
    .memory_addr(memory_addr), .memory_read_data(memory_read_data),
    .digest(digest), .match(match), .leading_zeros(leading_zeros),
    .meets_target(meets_target), .digest_valid(digest_valid),
    .digest_ready(digest_ready), .done(done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];
  always @(posedge clk) memory_read_data <= mem[memory_addr];

  typedef struct {
    logic [255:0] digest;
    logic         match;
    logic [8:0]   lz;
    logic         meets;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic int model_lz(input logic [255:0] d);
    int n = 0;
    while (n < 256 && d[255-n] == 1'b0) n++;
    return n;
  endfunction

  function automatic logic [255:0] mem_digest(input logic [15:0] addr);
    logic [255:0] d = '0;
    for (int i = 0; i < 8; i++) d = {d[223:0], mem[16'(addr + i)]};
    return d;
  endfunction

  task automatic run_check(input logic [15:0] addr, input logic [255:0] exp_ref, input logic [7:0] diff);
    exp_t e;
    int k;
    e.digest = mem_digest(addr);
    e.match  = (e.digest == exp_ref);
`ifdef SHA256_DIFFICULTY_CHECK_EN
    e.lz    = 9'(model_lz(e.digest));
    e.meets = (model_lz(e.digest) >= int'(diff));
`else
    e.lz    = 9'd0;
    e.meets = 1'b0;
`endif
    sb.push_back(e);
    @(negedge clk);
    hash_addr = addr; expected_digest = exp_ref; difficulty = diff; start = 1'b1;
    check("done_before_start", done, 1);
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!digest_valid && k < 40) begin
      check("read_addr", memory_addr, 16'(addr + (k < 8 ? k : 8)));
      check("no_write", enable_write, 0);
      @(posedge clk); @(negedge clk);
      k++;
    end
    check("latency", k, 10);
    e = sb.pop_front();
    if (digest_valid) begin
      check("digest", digest, e.digest);
      check("match", match, e.match);
      check("leading_zeros", leading_zeros, e.lz);
      check("meets_target", meets_target, e.meets);
      check("done_in_hold", done, 0);
    end
  endtask

  task automatic ack();
    @(negedge clk); digest_ready = 1'b1;
    @(posedge clk); @(negedge clk); digest_ready = 1'b0;
    check("ack_valid_low", digest_valid, 0);
    check("ack_done", done, 1);
  endtask

  logic [255:0] ref_a;
  logic [255:0] snap;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'd0;
    for (int i = 0; i < 8; i++) mem[16'h0040 + i] = 32'h11111111 * (i + 1);
    for (int i = 0; i < 8; i++) mem[16'(16'hFFFC + i)] = 32'hA0 + i;
    mem[16'h0100] = 32'h00000FFF;
    for (int i = 1; i < 8; i++) mem[16'h0100 + i] = 32'hFFFFFFFF;
    ref_a = mem_digest(16'h0040);

    repeat (2) @(negedge clk);
    check("rst_done", done, 1);
    check("rst_valid", digest_valid, 0);
    check("rst_addr", memory_addr, 0);
    check("rst_digest", digest, 0);
    check("rst_match", match, 0);
    check("rst_lz", leading_zeros, 0);
    check("rst_meets", meets_target, 0);
    check("rst_write", enable_write, 0);
    rst_n = 1'b1;

    // ready asserted with nothing valid must not disturb idle
    @(negedge clk); digest_ready = 1'b1;
    @(posedge clk); @(negedge clk); digest_ready = 1'b0;
    check("early_ready_done", done, 1);

    run_check(16'h0040, ref_a, 8'd0);
    check("basic_digest_const", digest, 256'h11111111222222223333333344444444555555556666666677777777_88888888);
    check("basic_match_const", match, 1);
    ack();

    // mismatch, then long hold with a start pulse that must be ignored
    run_check(16'h0040, ref_a ^ 256'd1, 8'd0);
    check("flip_match_const", match, 0);
    snap = digest;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); @(negedge clk);
      start = (i == 5);
      check("hold_valid", digest_valid, 1);
      check("hold_done", done, 0);
      check("hold_digest", digest, snap);
      check("hold_addr", memory_addr, 16'h0048);
    end
    digest_ready = 1'b1; start = 1'b1;
    @(posedge clk); @(negedge clk);
    digest_ready = 1'b0; start = 1'b0;
    check("hs_valid", digest_valid, 0);
    check("hs_done", done, 1);
    @(posedge clk); @(negedge clk);
    check("hs_start_ignored", done, 1);
    check("hs_addr_still", memory_addr, 16'h0048);
    check("idle_keeps_digest", digest, snap);

    run_check(16'hFFFC, '0, 8'd0);
    check("wrap_word4", digest[127:96], 32'hA4);
    ack();

    run_check(16'h0100, '0, 8'd20);
`ifdef SHA256_DIFFICULTY_CHECK_EN
    check("lz20_const", leading_zeros, 20);
    check("meets20_const", meets_target, 1);
`else
    check("lz_off_const", leading_zeros, 0);
    check("meets_off_const", meets_target, 0);
`endif
    ack();
    run_check(16'h0100, '0, 8'd21);
    check("meets21_const", meets_target, 0);
    ack();
    run_check(16'h0200, '0, 8'd255);
    ack();

    // reset in the middle of a read
    @(negedge clk); hash_addr = 16'h0040; start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    #1;
    check("mid_rst_addr", memory_addr, 0);
    check("mid_rst_digest", digest, 0);
    check("mid_rst_match", match, 0);
    check("mid_rst_valid", digest_valid, 0);
    check("mid_rst_done", done, 1);
    check("mid_rst_lz", leading_zeros, 0);
    @(negedge clk); rst_n = 1'b1;
    run_check(16'h0040, ref_a, 8'd0);
    ack();

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
